// File: rtl/button_reader_if.sv
// Button pad to LED-control bundle: raw active-low button in, debounced level and events out.
// The reader owns the slave side; whoever drives the pad and consumes events uses master.
interface button_reader_if;
    logic btn_n;
    logic btn_level;
    logic press_pulse;
    logic short_pulse;
    logic long_pulse;
    logic hold_active;

    modport master (
        output btn_n,
        input  btn_level,
        input  press_pulse,
        input  short_pulse,
        input  long_pulse,
        input  hold_active
    );

    modport slave (
        input  btn_n,
        output btn_level,
        output press_pulse,
        output short_pulse,
        output long_pulse,
        output hold_active
    );
endinterface

// File: rtl/button_reader.sv
// Synchronises and debounces one active-low push-button, emitting press / short-release /
// long-hold pulses plus a clean level, all registered.
module button_reader #(
    parameter int unsigned DEBOUNCE_CYCLES   = 270_000,
    parameter int unsigned LONG_PRESS_CYCLES = 27_000_000,
    parameter int unsigned CNT_W             = 25
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    button_reader_if.slave  btn_io
);

    localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StPressWait,
        StPressed,
        StLongHeld,
        StReleaseWait
    } state_e;

    state_e           state_q;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] deb_cnt_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             long_fired_q;
    logic             btn_level_q;
    logic             press_q, short_q, long_q;
    logic             hold_active_q;
    logic             btn_s;

    assign btn_s = ~sync2_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= StIdle;
            deb_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            long_fired_q  <= 1'b0;
            btn_level_q   <= 1'b0;
            press_q       <= 1'b0;
            short_q       <= 1'b0;
            long_q        <= 1'b0;
            hold_active_q <= 1'b0;
        end else begin
            sync1_q <= btn_io.btn_n;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (btn_s) begin
                        state_q   <= StPressWait;
                        deb_cnt_q <= '0;
                    end
                end
                StPressWait: begin
                    if (!btn_s) begin
                        state_q   <= StIdle;
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q == DebLast) begin
                        state_q      <= StPressed;
                        press_q      <= 1'b1;
                        btn_level_q  <= 1'b1;
                        hold_cnt_q   <= '0;
                        long_fired_q <= 1'b0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + CntOne;
                    end
                end
                StPressed: begin
                    if (!btn_s) begin
                        state_q   <= StReleaseWait;
                        deb_cnt_q <= '0;
                    end else if (hold_cnt_q == HoldLast) begin
                        state_q       <= StLongHeld;
                        long_q        <= 1'b1;
                        long_fired_q  <= 1'b1;
                        hold_active_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CntOne;
                    end
                end
                StLongHeld: begin
                    if (!btn_s) begin
                        state_q   <= StReleaseWait;
                        deb_cnt_q <= '0;
                    end
                end
                StReleaseWait: begin
                    // Bounce back to the held state keeps hold_cnt where it was.
                    if (btn_s) begin
                        state_q <= long_fired_q ? StLongHeld : StPressed;
                    end else if (deb_cnt_q == DebLast) begin
                        state_q       <= StIdle;
                        short_q       <= ~long_fired_q;
                        btn_level_q   <= 1'b0;
                        hold_active_q <= 1'b0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + CntOne;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign btn_io.btn_level   = btn_level_q;
    assign btn_io.press_pulse = press_q;
    assign btn_io.short_pulse = short_q;
    assign btn_io.long_pulse  = long_q;
    assign btn_io.hold_active = hold_active_q;

endmodule
